// File: rtl/eth_tx_frame_sched.sv
// Round-robin frame scheduler for the RGMII TX byte stream: adds preamble/SFD,
// enforces a speed-scaled inter-frame gap and drops frames when the link goes away.
module eth_tx_frame_sched #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int CNT_W        = 16
) (
  input  logic       clk_125mhz,
  input  logic       reset,
  input  logic       phy_link_status,
  input  logic [1:0] phy_speed_status,
  input  logic [7:0] s0_axis_tdata,
  input  logic       s0_axis_tvalid,
  input  logic       s0_axis_tlast,
  output logic       s0_axis_tready,
  input  logic [7:0] s1_axis_tdata,
  input  logic       s1_axis_tvalid,
  input  logic       s1_axis_tlast,
  output logic       s1_axis_tready,
  output logic [7:0] tx_axis_rgmii_tdata,
  output logic       tx_axis_rgmii_tvalid,
  input  logic       tx_axis_rgmii_tready,
  output logic       grant,
  output logic       busy,
  output logic       tx_frame_done,
  output logic       tx_abort,
  output logic       tx_underrun
);

  localparam int              PW       = $clog2(PREAMBLE_LEN + 2);
  localparam logic [PW-1:0]   PRE_LAST = PW'(PREAMBLE_LEN);
  localparam logic [CNT_W-1:0] IFG_10M  = CNT_W'(IFG_BYTES * 100);
  localparam logic [CNT_W-1:0] IFG_100M = CNT_W'(IFG_BYTES * 10);
  localparam logic [CNT_W-1:0] IFG_1G   = CNT_W'(IFG_BYTES);
  localparam logic [7:0]      PRE_BYTE = 8'h55;
  localparam logic [7:0]      SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    DATA  = 3'd2,
    IFG   = 3'd3,
    FLUSH = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       last;
  } src_t;

  state_t           state, state_nxt;
  logic             grant_q, grant_nxt;
  logic [PW-1:0]    pre_cnt, pre_nxt;
  logic [CNT_W-1:0] ifg_cnt, ifg_nxt;
  logic [CNT_W-1:0] ifg_load;

  src_t src [2];
  src_t g;
  logic g_ready;
  logic g_hs;
  logic req_any, req_both;

  logic [7:0] out_tdata;
  logic       out_tvalid;
  logic       done_p, abort_p, underrun_p;

  assign src[0] = '{data: s0_axis_tdata, valid: s0_axis_tvalid, last: s0_axis_tlast};
  assign src[1] = '{data: s1_axis_tdata, valid: s1_axis_tvalid, last: s1_axis_tlast};
  assign g      = src[grant_q];
  assign g_hs   = g.valid && g_ready;

  assign req_any  = s0_axis_tvalid || s1_axis_tvalid;
  assign req_both = s0_axis_tvalid && s1_axis_tvalid;

  // Gap length follows the speed seen on the cycle the frame ends; code 3 runs as gigabit.
  always_comb begin
    ifg_load = IFG_1G;
    case (phy_speed_status)
      2'd0:    ifg_load = IFG_10M;
      2'd1:    ifg_load = IFG_100M;
      default: ifg_load = IFG_1G;
    endcase
  end

  always_ff @(posedge clk_125mhz) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= 1'b1;
      pre_cnt <= '0;
      ifg_cnt <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      pre_cnt <= pre_nxt;
      ifg_cnt <= ifg_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    pre_nxt    = pre_cnt;
    ifg_nxt    = ifg_cnt;
    out_tdata  = '0;
    out_tvalid = 1'b0;
    g_ready    = 1'b0;
    done_p     = 1'b0;
    abort_p    = 1'b0;
    underrun_p = 1'b0;

    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (phy_link_status && req_any) begin
            // On a tie the source that did not win last time goes next.
            grant_nxt = req_both ? ~grant_q : s1_axis_tvalid;
            pre_nxt   = '0;
            state_nxt = PRE;
          end
        end

        PRE: begin
          if (!phy_link_status) begin
            abort_p   = 1'b1;
            pre_nxt   = '0;
            state_nxt = FLUSH;
          end else begin
            out_tvalid = 1'b1;
            out_tdata  = (pre_cnt == PRE_LAST) ? SFD_BYTE : PRE_BYTE;
            if (tx_axis_rgmii_tready) begin
              if (pre_cnt == PRE_LAST) begin
                pre_nxt   = '0;
                state_nxt = DATA;
              end else begin
                pre_nxt = pre_cnt + PW'(1);
              end
            end
          end
        end

        DATA: begin
          // Source ready still follows downstream on a link-drop cycle, so the
          // byte taken then is simply discarded along with the rest of the frame.
          g_ready    = tx_axis_rgmii_tready;
          out_tdata  = g.data;
          out_tvalid = g.valid && phy_link_status;
          underrun_p = !g.valid;
          if (g_hs && g.last) begin
            done_p    = 1'b1;
            ifg_nxt   = ifg_load;
            state_nxt = IFG;
          end else if (!phy_link_status) begin
            abort_p   = 1'b1;
            state_nxt = FLUSH;
          end
        end

        FLUSH: begin
          g_ready = 1'b1;
          if (g.valid && g.last) begin
            ifg_nxt   = ifg_load;
            state_nxt = IFG;
          end
        end

        IFG: begin
          if (ifg_cnt <= CNT_W'(1)) begin
            ifg_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            ifg_nxt = ifg_cnt - CNT_W'(1);
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  assign s0_axis_tready       = g_ready && !grant_q;
  assign s1_axis_tready       = g_ready && grant_q;
  assign tx_axis_rgmii_tdata  = out_tdata;
  assign tx_axis_rgmii_tvalid = out_tvalid;
  assign grant                = grant_q;
  assign busy                 = !reset && (state != IDLE);
  assign tx_frame_done        = done_p;
  assign tx_abort             = abort_p;
  assign tx_underrun          = underrun_p;

endmodule

// File: tb/tb_eth_tx_frame_sched.sv
// Scoreboard bench: stimulus pushes expected downstream bytes, grants and gap
// lengths; a negedge monitor pops and compares as the DUT produces them.
module tb_eth_tx_frame_sched;

  localparam int PRE = 7;

  logic       clk_125mhz = 1'b0;
  logic       reset = 1'b1;
  logic       phy_link_status = 1'b1;
  logic [1:0] phy_speed_status = 2'd2;
  logic [7:0] s0_axis_tdata = '0;
  logic       s0_axis_tvalid = 1'b0, s0_axis_tlast = 1'b0, s0_axis_tready;
  logic [7:0] s1_axis_tdata = '0;
  logic       s1_axis_tvalid = 1'b0, s1_axis_tlast = 1'b0, s1_axis_tready;
  logic [7:0] tx_axis_rgmii_tdata;
  logic       tx_axis_rgmii_tvalid, tx_axis_rgmii_tready = 1'b0;
  logic       grant, busy, tx_frame_done, tx_abort, tx_underrun;

  eth_tx_frame_sched #(.PREAMBLE_LEN(PRE), .IFG_BYTES(12), .CNT_W(16)) dut (
    .clk_125mhz(clk_125mhz), .reset(reset),
    .phy_link_status(phy_link_status), .phy_speed_status(phy_speed_status),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .tx_axis_rgmii_tdata(tx_axis_rgmii_tdata), .tx_axis_rgmii_tvalid(tx_axis_rgmii_tvalid),
    .tx_axis_rgmii_tready(tx_axis_rgmii_tready),
    .grant(grant), .busy(busy), .tx_frame_done(tx_frame_done),
    .tx_abort(tx_abort), .tx_underrun(tx_underrun)
  );

  initial forever #4 clk_125mhz = ~clk_125mhz;

  int tests = 0, fails = 0;
  int cyc = 0;
  int rate = 1;
  int s0_sent = 0, s1_sent = 0;
  int gap_at = -1, gap_left = 0;
  int done_cnt = 0, abort_cnt = 0, underrun_cnt = 0;
  int rise_cyc = 0;
  logic hs0 = 1'b0, hs1 = 1'b0;

  logic [8:0] s0q[$];
  logic [8:0] s1q[$];
  logic [7:0] exp_q[$];
  logic       exp_grant[$];
  int         exp_ifg[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Queue one frame on a source; the first n_exp bytes of preamble+SFD+data
  // are expected downstream (negative = all of them).
  task automatic send(input int src, input int n, input logic [7:0] base, input int n_exp);
    int k = 0;
    logic [7:0] b;
    for (int i = 0; i <= PRE; i++) begin
      if (n_exp < 0 || k < n_exp) exp_q.push_back(i == PRE ? 8'hD5 : 8'h55);
      k++;
    end
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      if (src == 0) s0q.push_back({i == n - 1, b});
      else          s1q.push_back({i == n - 1, b});
      if (n_exp < 0 || k < n_exp) exp_q.push_back(b);
      k++;
    end
  endtask

  task automatic clr_counts();
    done_cnt = 0; abort_cnt = 0; underrun_cnt = 0; s0_sent = 0; s1_sent = 0;
  endtask

  task automatic wait_idle(input int max, input string name);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_125mhz); #1;
      if (!busy && s0q.size() == 0 && s1q.size() == 0 && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Returns on the rising edge right after the last expected byte was taken.
  task automatic wait_exp_empty(input int max, input string name);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_125mhz); #1;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    chk(name, 32'(ok), 32'd1);
    @(posedge clk_125mhz);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_grant_left"}, 32'(exp_grant.size()), 32'd0);
    chk({tag, "_ifg_left"}, 32'(exp_ifg.size()), 32'd0);
  endtask

  // Source and sink driver: pop on handshakes seen at the last negedge, redrive 1ns later.
  initial begin
    forever begin
      @(posedge clk_125mhz);
      cyc++;
      if (hs0 && s0q.size() > 0) begin void'(s0q.pop_front()); s0_sent++; end
      if (hs1 && s1q.size() > 0) begin void'(s1q.pop_front()); s1_sent++; end
      #1;
      tx_axis_rgmii_tready = (rate <= 1) || (cyc % rate == 0);
      if (s0q.size() > 0 && !(s0_sent == gap_at && gap_left > 0)) begin
        s0_axis_tvalid = 1'b1;
        {s0_axis_tlast, s0_axis_tdata} = s0q[0];
      end else begin
        s0_axis_tvalid = 1'b0;
        if (s0q.size() > 0) gap_left--;
      end
      if (s1q.size() > 0) begin
        s1_axis_tvalid = 1'b1;
        {s1_axis_tlast, s1_axis_tdata} = s1q[0];
      end else begin
        s1_axis_tvalid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_busy = 1'b0;
    logic ifg_vld = 1'b0;
    int   ifg_start = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk_125mhz);
      hs0 = s0_axis_tvalid && s0_axis_tready;
      hs1 = s1_axis_tvalid && s1_axis_tready;
      if (reset) begin
        prev_busy = 1'b0;
        ifg_vld   = 1'b0;
      end else begin
        if (tx_axis_rgmii_tvalid && tx_axis_rgmii_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(tx_axis_rgmii_tdata), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", 32'(tx_axis_rgmii_tdata), 32'(e));
          end
        end
        if (tx_frame_done) done_cnt++;
        if (tx_abort)      abort_cnt++;
        if (tx_underrun) begin
          underrun_cnt++;
          chk("underrun_tvalid", 32'(tx_axis_rgmii_tvalid), 32'd0);
        end
        if (busy && !prev_busy) begin
          rise_cyc = cyc;
          if (exp_grant.size() == 0) chk("unexpected_grant", 32'(grant), 32'hFFFF_FFFF);
          else chk("grant_order", 32'(grant), 32'(exp_grant.pop_front()));
        end
        if (ifg_vld && prev_busy && !busy) begin
          ifg_vld = 1'b0;
          if (exp_ifg.size() == 0) chk("unexpected_ifg", 32'(cyc - ifg_start - 1), 32'hFFFF_FFFF);
          else chk("ifg_len", 32'(cyc - ifg_start - 1), 32'(exp_ifg.pop_front()));
        end
        if ((hs0 && s0_axis_tlast) || (hs1 && s1_axis_tlast)) begin
          ifg_vld   = 1'b1;
          ifg_start = cyc;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #(8 * 30000);
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(posedge clk_125mhz);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk_125mhz); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tvalid", 32'(tx_axis_rgmii_tvalid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    chk("rst_s0_tready", 32'(s0_axis_tready), 32'd0);
    chk("rst_s1_tready", 32'(s1_axis_tready), 32'd0);
    chk("rst_pulses", 32'({tx_frame_done, tx_abort, tx_underrun}), 32'd0);

    // Both sources busy with 3 frames each: strict alternation starting at 0
    clr_counts();
    send(0, 6, 8'h10, -1); send(1, 6, 8'h90, -1);
    send(0, 6, 8'h30, -1); send(1, 6, 8'hB0, -1);
    send(0, 6, 8'h50, -1); send(1, 6, 8'hD0, -1);
    for (int i = 0; i < 6; i++) begin
      exp_grant.push_back(i[0]);
      exp_ifg.push_back(12);
    end
    wait_idle(1000, "rr_timeout");
    chk("rr_done_cnt", 32'(done_cnt), 32'd6);
    end_checks("rr");

    // 1000M, single 64-byte frame from s0
    clr_counts();
    send(0, 64, 8'h00, -1);
    exp_grant.push_back(1'b0); exp_ifg.push_back(12);
    wait_idle(500, "g1_timeout");
    chk("g1_done_cnt", 32'(done_cnt), 32'd1);
    end_checks("g1");

    // 100M with downstream ready 1-in-10, s1 frame
    clr_counts();
    phy_speed_status = 2'd1; rate = 10;
    send(1, 8, 8'hA0, -1);
    exp_grant.push_back(1'b1); exp_ifg.push_back(120);
    wait_idle(1000, "m100_timeout");
    chk("m100_done_cnt", 32'(done_cnt), 32'd1);
    end_checks("m100");

    // 10M, s0 frame
    clr_counts();
    phy_speed_status = 2'd0; rate = 100;
    send(0, 6, 8'hC0, -1);
    exp_grant.push_back(1'b0); exp_ifg.push_back(1200);
    wait_idle(4000, "m10_timeout");
    chk("m10_done_cnt", 32'(done_cnt), 32'd1);
    end_checks("m10");

    // Link loss after data byte 20 of a 60-byte frame
    clr_counts();
    phy_speed_status = 2'd2; rate = 1;
    send(0, 60, 8'h40, PRE + 1 + 20);
    exp_grant.push_back(1'b0); exp_ifg.push_back(12);
    wait_exp_empty(200, "abort_wait");
    #1 phy_link_status = 1'b0;
    wait_idle(300, "abort_timeout");
    chk("abort_cnt", 32'(abort_cnt), 32'd1);
    chk("abort_done_cnt", 32'(done_cnt), 32'd0);
    chk("abort_drained", 32'(s0_sent), 32'd60);
    end_checks("abort");
    phy_link_status = 1'b1;

    // Underrun: s0 stalls 3 cycles after 5 data bytes; speed code 3 acts as 1000M
    clr_counts();
    phy_speed_status = 2'd3;
    gap_at = 5; gap_left = 3;
    send(0, 16, 8'h70, -1);
    exp_grant.push_back(1'b0); exp_ifg.push_back(12);
    wait_idle(300, "ur_timeout");
    chk("ur_cnt", 32'(underrun_cnt), 32'd3);
    chk("ur_done_cnt", 32'(done_cnt), 32'd1);
    end_checks("ur");
    gap_at = -1; phy_speed_status = 2'd2;

    // Reset during preamble, then a lone s1 request is served at once
    clr_counts();
    send(0, 8, 8'hE0, 3);
    exp_grant.push_back(1'b0);
    wait_exp_empty(100, "rpre_wait");
    s0q.delete();
    #1 reset = 1'b1;
    @(negedge clk_125mhz); #1;
    chk("rpre_tvalid0", 32'(tx_axis_rgmii_tvalid), 32'd0);
    @(negedge clk_125mhz); #1;
    chk("rpre_busy", 32'(busy), 32'd0);
    chk("rpre_tvalid1", 32'(tx_axis_rgmii_tvalid), 32'd0);
    chk("rpre_grant", 32'(grant), 32'd1);
    @(posedge clk_125mhz); #1 reset = 1'b0;
    @(negedge clk_125mhz);
    k = cyc;
    send(1, 5, 8'h20, -1);
    exp_grant.push_back(1'b1); exp_ifg.push_back(12);
    wait_idle(200, "rpre_timeout");
    chk("rpre_grant_latency", 32'(rise_cyc - k), 32'd2);
    chk("rpre_done_cnt", 32'(done_cnt), 32'd1);
    end_checks("rpre");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_sched.md
Name: eth_tx_frame_sched

Overview:
Frame-level scheduler in front of the RGMII transmit byte interface (tx_axis_rgmii_*).
- Arbitrates two AXI-Stream frame sources round-robin, one whole frame per grant.
- Prepends preamble/SFD to each frame.
- Enforces a speed-scaled inter-frame gap.
- Aborts or flushes frames on link loss.
Sources supply complete frames including FCS. This block does no CRC or padding.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before SFD (0xD5)
IFG_BYTES, 12, minimum inter-frame gap in byte times
CNT_W, 16, width of IFG cycle counter

Ports:
clk_125mhz  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high
phy_link_status  input  1  link up(1)/down(0); synchronous to clk_125mhz
phy_speed_status  input  2  10M(0), 100M(1), 1000M(2); synchronous to clk_125mhz
s0_axis_tdata  input  8  source 0 byte
s0_axis_tvalid  input  1  source 0 valid
s0_axis_tlast  input  1  source 0 last byte of frame
s0_axis_tready  output  1  source 0 ready
s1_axis_tdata / s1_axis_tvalid / s1_axis_tlast  input  8/1/1  source 1, same meaning as source 0
s1_axis_tready  output  1  source 1 ready
tx_axis_rgmii_tdata  output  8  byte to RGMII TX
tx_axis_rgmii_tvalid  output  1  byte valid
tx_axis_rgmii_tready  input  1  RGMII TX accepts byte
grant  output  1  currently/last granted source index
busy  output  1  state != IDLE
tx_frame_done  output  1  1-cycle pulse: tlast byte accepted downstream
tx_abort  output  1  1-cycle pulse: frame aborted (link down)
tx_underrun  output  1  1-cycle pulse per cycle the granted source has tvalid=0 in DATA

Behaviour:
- Transfer rule: a byte moves on any interface only when tvalid && tready in the same cycle.
- Reset values: state=IDLE; grant=1, so source 0 wins the first tie; preamble counter=0; IFG counter=0; all outputs 0.
- State IDLE:
  - tx_axis_rgmii_tvalid=0; both s*_tready=0.
  - If phy_link_status=1 and any s*_tvalid=1: grant the requester; if both request, grant the one != grant. Go to PRE next cycle.
  - tvalid is not required to persist; the grant is latched.
- State PRE:
  - tvalid=1; tdata=0x55 for beats 0..PREAMBLE_LEN-1, then 0xD5.
  - Counter advances only on downstream handshake.
  - After SFD is accepted, go to DATA.
  - First preamble byte appears 1 cycle after the request is seen in IDLE.
- State DATA, combinational pass-through of the granted source:
  - tx_axis_rgmii_tdata = s[g]_tdata; tvalid = s[g]_tvalid; s[g]_tready = tx_axis_rgmii_tready; the other source's tready=0.
  - Granted tvalid=0 gives tvalid=0 plus a tx_underrun pulse each cycle. No filler is inserted; sources must stream frames contiguously at the downstream rate.
  - Handshake with tlast=1: tx_frame_done pulse; load IFG counter; go to IFG.
- State IFG:
  - tvalid=0; both treadys 0.
  - IFG counter loaded with IFG_BYTES × {100, 10, 1} for speed {0, 1, 2}; speed 3 is treated as 1000M.
  - Decrements each cycle; at 1 → IDLE, so the gap is exactly the loaded value in cycles.
- Link loss:
  - phy_link_status=0 in PRE: tvalid=0, tx_abort pulse, go to FLUSH.
  - phy_link_status=0 in DATA: same, except the current cycle's downstream transfer is suppressed (tvalid forced 0 that cycle).
  - FLUSH: s[g]_tready=1 and tvalid=0; bytes are discarded until a tlast handshake, then go to IFG. If that frame's tlast was already consumed, go to IFG directly.
  - phy_link_status=0 in IDLE or IFG: no grant is issued; IFG still completes.
- Speed change mid-frame is not handled specially; the IFG load uses the speed sampled at the tlast cycle.
- Simultaneous events: the tlast handshake and link drop in the same cycle count as done; tx_frame_done fires, tx_abort does not.
- Reset mid-frame: return to IDLE immediately; outputs 0; partial source frames are not flushed.

Test Plan:
- 1000M, s0 sends a 64-byte frame, tready=1 → downstream sees 55×7, D5, 64 bytes; tx_frame_done at the last byte; next grant no earlier than 12 cycles later.
- Both sources continuously valid, 3 frames each → grant order 0,1,0,1,0,1; each frame is preceded by 8 preamble/SFD bytes.
- 100M (tready 1-in-10), s1 frame → IFG=120 cycles after tlast; 10M → IFG=1200 cycles.
- Link drops after data byte 20 of a 60-byte frame → tx_abort pulse; tvalid=0 from that cycle; the remaining 40 bytes are drained with tready=1 and none are forwarded; IDLE is reached after the IFG.
- s0 deasserts tvalid for 3 cycles mid-frame → 3 tx_underrun pulses; downstream tvalid=0 for those cycles; byte order is preserved.
- Reset asserted during PRE → next cycle state=IDLE, tvalid=0, grant=1; a subsequent single request from s1 is granted immediately.
